mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port 256x16 main memory between the CPU core (port A) and the host loader/debug port (port B).
- Sits between both requesters and the memory array; drives the memory's one enable/write/address/data interface.
- Supports round-robin or fixed-priority-with-anti-starvation policy.
- Supports a lock so read-modify-write sequences (ISZ, BSA) complete atomically.

Parameters:
AW, 8, memory address width (256 words)
DW, 16, memory data width
RR_MODE, 1, 1 = round-robin; 0 = fixed priority A over B with starvation guard
MAX_WAIT, 4, fixed mode only: consecutive denied cycles of B before B is forced ahead of A (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_a  in  1  CPU access request, held until gnt_a
we_a  in  1  CPU write enable (1 = write, 0 = read)
lock_a  in  1  CPU lock: retain ownership after this access
addr_a  in  AW  CPU address
wdata_a  in  DW  CPU write data
gnt_a  out  1  CPU access accepted this cycle
rvalid_a  out  1  CPU read data valid
rdata_a  out  DW  CPU read data
req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for the host port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after a read strobe (synchronous read)

Behaviour:
- Clock/reset: one clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - Registered state: lock_owner = NONE, wait_cnt = 0, last_grant = B (so A wins the first contention), rvalid_a = rvalid_b = 0.
  - Combinational outputs are forced 0 while rst = 1: gnt_a, gnt_b, mem_en, mem_we.
- Grants:
  - gnt_x is combinational from the current req_x and the registered state.
  - At most one grant per cycle; gnt_a and gnt_b are never both 1.
  - A granted access is issued to memory in the same cycle: mem_en = 1, and mem_we, mem_addr, mem_wdata come from the winner's inputs.
  - With no grant: mem_en = 0 and mem_we = 0.
- Arbitration order, evaluated each cycle:
  1. If lock_owner = X, only port X can be granted. The other port waits regardless of policy or wait_cnt.
  2. Otherwise, with a single requester, that requester is granted.
  3. Otherwise, with both requesting:
     - RR_MODE = 1: grant the port that is not last_grant.
     - RR_MODE = 0: grant B if wait_cnt = MAX_WAIT, else grant A.
- last_grant updates to the winner on every grant.
- wait_cnt (fixed mode only):
  - Increments each cycle that req_b = 1 and gnt_b = 0, saturating at MAX_WAIT.
  - Clears on gnt_b, or on any cycle with req_b = 0.
  - Not used in round-robin mode.
- Lock:
  - A grant with lock_x = 1 sets lock_owner = X on the next edge.
  - lock_owner clears on the first edge where the owner's lock_x = 0, whether or not the owner is requesting.
  - So the final access of a locked sequence is presented with lock_x = 0. Ownership ends after that access, and the other port may be granted on the following cycle.
  - A lock asserted without a grant has no effect.
- Read return:
  - A granted read (we_x = 0) sets rvalid_x = 1 for exactly the next cycle.
  - rdata_x is mem_rdata passed through; it is meaningful only while rvalid_x = 1.
  - Writes never raise rvalid.
  - Back-to-back reads by one port give back-to-back rvalid pulses, in order.
- Requester rules:
  - A requester holds req, we, addr, wdata, lock stable until it sees gnt.
  - Dropping req before grant is legal: the request is withdrawn and no access occurs.
- Reset mid-operation:
  - Pending rvalid is lost.
  - lock_owner returns to NONE.
  - No memory strobe is issued while rst = 1.
- Address width: memory wraps naturally at 2^AW words. No range checking.

Test Plan:
1. Single-port read: addr_a = 8'h10 holds 16'h1234; req_a = 1, we_a = 0 -> gnt_a in the same cycle, mem_en = 1, mem_addr = 8'h10; next cycle rvalid_a = 1, rdata_a = 16'h1234; rvalid_b stays 0.
2. RR contention (RR_MODE = 1): both ports request continuous reads after reset -> grants A, B, A, B; each rvalid pulse lands one cycle after its port's grant.
3. Fixed priority starvation (RR_MODE = 0, MAX_WAIT = 4): A and B request continuously -> A is granted 4 cycles, B is granted on the 5th, then the pattern repeats. With MAX_WAIT = 2 the period is 3.
4. Lock for ISZ: A reads 8'h20 with lock_a = 1 while B requests -> B is denied. A then writes 16'h0008 to 8'h20 with lock_a = 0 -> B is granted the cycle after A's write, and B's read of 8'h20 returns 16'h0008.
5. Write/read-back: B writes 16'hBEEF to 8'hFF, then reads 8'hFF -> rvalid_b with rdata_b = 16'hBEEF; no rvalid after the write.
6. Async reset mid-lock: A holds the lock and rst pulses between clock edges -> outputs go to reset values immediately, lock_owner = NONE; after release, a pending req_b is granted in the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read memory between the
// CPU core (port A) and the host loader/debug port (port B).
//
// Handshake (both ports): a requester raises req_x together with we_x,
// lock_x, addr_x and wdata_x and holds all of them stable until it sees
// gnt_x. gnt_x high means the access is issued to memory in that same
// cycle. Dropping req_x before gnt_x withdraws the request. A granted read
// returns rvalid_x for exactly the following cycle, with rdata_x valid
// only while rvalid_x is high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req/we/lock/addr/wdata_{a,b}   requester inputs
//   gnt/rvalid/rdata_{a,b}         requester outputs
//   mem_en/we/addr/wdata           memory strobe and command
//   mem_rdata                      memory read data (one cycle after strobe)
//   dbg_lock_owner_o               lock owner state: 0 none, 1 A, 2 B
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_lock_owner_o
);

  localparam int WCW = 4;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  owner_e         lock_owner_q, lock_owner_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  // 1 = most recent grant went to B. Resets to 1 so A wins the first tie.
  logic           last_b_q, last_b_d;
  logic           rvalid_a_q, rvalid_b_q;
  logic           win_a, win_b;

  // Arbitration: lock owner first, then lone requester, then policy.
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (lock_owner_q == OWN_A) begin
      win_a = req_a;
    end else if (lock_owner_q == OWN_B) begin
      win_b = req_b;
    end else if (req_a && req_b) begin
      if (RR_MODE != 0) begin
        win_a = last_b_q;
        win_b = !last_b_q;
      end else if (wait_cnt_q == WAIT_MAX) begin
        win_b = 1'b1;
      end else begin
        win_a = 1'b1;
      end
    end else begin
      win_a = req_a;
      win_b = req_b;
    end
  end

  // Grants are suppressed for as long as reset is held, so no strobe escapes.
  assign gnt_a = win_a & ~rst;
  assign gnt_b = win_b & ~rst;

  always_comb begin
    mem_en    = gnt_a | gnt_b;
    mem_we    = 1'b0;
    mem_addr  = addr_a;
    mem_wdata = wdata_a;
    if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end else if (gnt_a) begin
      mem_we    = we_a;
    end
  end

  // Next-state for lock ownership, last winner and B's starvation counter.
  always_comb begin
    lock_owner_d = lock_owner_q;
    // The owner releases on the first edge it presents lock low,
    // whether or not it is requesting.
    if (lock_owner_q == OWN_A && !lock_a) lock_owner_d = OWN_NONE;
    if (lock_owner_q == OWN_B && !lock_b) lock_owner_d = OWN_NONE;
    if (gnt_a && lock_a) lock_owner_d = OWN_A;
    if (gnt_b && lock_b) lock_owner_d = OWN_B;

    last_b_d = last_b_q;
    if (gnt_a) last_b_d = 1'b0;
    if (gnt_b) last_b_d = 1'b1;

    wait_cnt_d = '0;
    if (RR_MODE == 0 && req_b && !gnt_b) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_owner_q <= OWN_NONE;
      wait_cnt_q   <= '0;
      last_b_q     <= 1'b1;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
    end else begin
      lock_owner_q <= lock_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      last_b_q     <= last_b_d;
      rvalid_a_q   <= gnt_a & ~we_a;
      rvalid_b_q   <= gnt_b & ~we_b;
    end
  end

  assign rvalid_a         = rvalid_a_q;
  assign rvalid_b         = rvalid_b_q;
  assign rdata_a          = mem_rdata;
  assign rdata_b          = mem_rdata;
  assign dbg_lock_owner_o = lock_owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (round-robin, fixed MAX_WAIT=4,
// fixed MAX_WAIT=2) share one stimulus stream; each owns a memory model.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int rst_pulses = 0;
  always @(posedge rst) rst_pulses++;

  // ---------------- stimulus and DUT wiring ----------------
  logic        req_a = 0, we_a = 0, lock_a = 0, req_b = 0, we_b = 0, lock_b = 0;
  logic [7:0]  addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;

  logic [2:0]  gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we;
  logic [15:0] rdata_a [3];
  logic [15:0] rdata_b [3];
  logic [7:0]  mem_addr [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic [1:0]  dbg_own [3];

  mem_arbiter #(.AW(8), .DW(16), .RR_MODE(1), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a[0]), .rvalid_a(rvalid_a[0]), .rdata_a(rdata_a[0]),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b[0]), .rvalid_b(rvalid_b[0]), .rdata_b(rdata_b[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .dbg_lock_owner_o(dbg_own[0]));

  mem_arbiter #(.AW(8), .DW(16), .RR_MODE(0), .MAX_WAIT(4)) u_fx4 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a[1]), .rvalid_a(rvalid_a[1]), .rdata_a(rdata_a[1]),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b[1]), .rvalid_b(rvalid_b[1]), .rdata_b(rdata_b[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .dbg_lock_owner_o(dbg_own[1]));

  mem_arbiter #(.AW(8), .DW(16), .RR_MODE(0), .MAX_WAIT(2)) u_fx2 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a[2]), .rvalid_a(rvalid_a[2]), .rdata_a(rdata_a[2]),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b[2]), .rvalid_b(rvalid_b[2]), .rdata_b(rdata_b[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]), .dbg_lock_owner_o(dbg_own[2]));

  // Unwritten words read as a fixed pattern; 8'h10 holds 16'h1234.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'h1234 : {8'hA5, a};
  endfunction

  // ---------------- memory arrays behind the DUTs ----------------
  bit [15:0] wmem [3][256];
  bit        wv   [3][256];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_en[k]) begin
        mem_rdata[k] <= wv[k][mem_addr[k]] ? wmem[k][mem_addr[k]] : init_val(mem_addr[k]);
        if (mem_we[k]) begin
          wmem[k][mem_addr[k]] = mem_wdata[k];
          wv[k][mem_addr[k]]   = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: who holds the lock (0 none, 1 A, 2 B), how many cycles
  // in a row B has been refused, who won last, and the read data owed
  // next cycle (one entry queue per port).
  int        rr_p [3] = '{1, 0, 0};
  int        mw_p [3] = '{4, 4, 2};
  int        m_owner [3];
  int        m_denied [3];
  int        m_last [3];
  logic [15:0] exp_qa [3][$];
  logic [15:0] exp_qb [3][$];
  bit [15:0] mmem [3][256];
  bit        mv   [3][256];
  int        seen_pulses = 0;

  function automatic logic [15:0] m_read(input int k, input logic [7:0] a);
    return mv[k][a] ? mmem[k][a] : init_val(a);
  endfunction

  // Winner this cycle: 0 none, 1 A, 2 B.
  function automatic int pick(input int k);
    if (m_owner[k] == 1) return req_a ? 1 : 0;
    if (m_owner[k] == 2) return req_b ? 2 : 0;
    if (!req_a && !req_b) return 0;
    if (req_a != req_b) return req_a ? 1 : 2;
    if (rr_p[k] != 0) return (m_last[k] == 1) ? 2 : 1;
    return (m_denied[k] >= mw_p[k]) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    if (rst || seen_pulses != rst_pulses) begin
      seen_pulses = rst_pulses;
      for (int k = 0; k < 3; k++) begin
        m_owner[k] = 0; m_denied[k] = 0; m_last[k] = 2;
        exp_qa[k].delete(); exp_qb[k].delete();
      end
    end
    for (int k = 0; k < 3; k++) begin
      int win;
      win = rst ? 0 : pick(k);
      chk($sformatf("m%0d_gnt_a", k), 32'(gnt_a[k]), 32'(win == 1));
      chk($sformatf("m%0d_gnt_b", k), 32'(gnt_b[k]), 32'(win == 2));
      chk($sformatf("m%0d_mem_en", k), 32'(mem_en[k]), 32'(win != 0));
      if (win == 1) begin
        chk($sformatf("m%0d_mem_we", k), 32'(mem_we[k]), 32'(we_a));
        chk($sformatf("m%0d_mem_addr", k), 32'(mem_addr[k]), 32'(addr_a));
        chk($sformatf("m%0d_mem_wdata", k), 32'(mem_wdata[k]), 32'(wdata_a));
      end else if (win == 2) begin
        chk($sformatf("m%0d_mem_we", k), 32'(mem_we[k]), 32'(we_b));
        chk($sformatf("m%0d_mem_addr", k), 32'(mem_addr[k]), 32'(addr_b));
        chk($sformatf("m%0d_mem_wdata", k), 32'(mem_wdata[k]), 32'(wdata_b));
      end else begin
        chk($sformatf("m%0d_mem_we_idle", k), 32'(mem_we[k]), 32'd0);
      end
      chk($sformatf("m%0d_rvalid_a", k), 32'(rvalid_a[k]), 32'(exp_qa[k].size() != 0));
      chk($sformatf("m%0d_rvalid_b", k), 32'(rvalid_b[k]), 32'(exp_qb[k].size() != 0));
      if (exp_qa[k].size() != 0 && rvalid_a[k])
        chk($sformatf("m%0d_rdata_a", k), 32'(rdata_a[k]), 32'(exp_qa[k][0]));
      if (exp_qb[k].size() != 0 && rvalid_b[k])
        chk($sformatf("m%0d_rdata_b", k), 32'(rdata_b[k]), 32'(exp_qb[k][0]));
      exp_qa[k].delete();
      exp_qb[k].delete();
      if (!rst) begin
        if (win == 1 && !we_a) exp_qa[k].push_back(m_read(k, addr_a));
        if (win == 2 && !we_b) exp_qb[k].push_back(m_read(k, addr_b));
        if (win == 1 && we_a) begin mmem[k][addr_a] = wdata_a; mv[k][addr_a] = 1'b1; end
        if (win == 2 && we_b) begin mmem[k][addr_b] = wdata_b; mv[k][addr_b] = 1'b1; end
        if (rr_p[k] == 0) begin
          if (req_b && win != 2) m_denied[k] = (m_denied[k] < mw_p[k]) ? m_denied[k] + 1 : mw_p[k];
          else m_denied[k] = 0;
        end
        if (win == 1 && lock_a) m_owner[k] = 1;
        else if (win == 2 && lock_b) m_owner[k] = 2;
        else if (m_owner[k] == 1 && !lock_a) m_owner[k] = 0;
        else if (m_owner[k] == 2 && !lock_b) m_owner[k] = 0;
        if (win != 0) m_last[k] = win;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic r, input logic w, input logic l,
                         input logic [7:0] ad, input logic [15:0] wd);
    req_a = r; we_a = w; lock_a = l; addr_a = ad; wdata_a = wd;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic l,
                         input logic [7:0] ad, input logic [15:0] wd);
    req_b = r; we_b = w; lock_b = l; addr_b = ad; wdata_b = wd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_a(0, 0, 0, 8'h00, 16'h0000);
    drive_b(0, 0, 0, 8'h00, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Contention winners per cycle (1 = A, 2 = B): RR, fixed/4, fixed/2.
  int seq [3][10] = '{'{1, 2, 1, 2, 1, 2, 1, 2, 1, 2},
                      '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2},
                      '{1, 1, 2, 1, 1, 2, 1, 1, 2, 1}};

  // ---------------- directed tests ----------------
  initial begin
    // Reset state, with both ports already requesting.
    drive_a(1, 0, 0, 8'h10, 16'h0000);
    drive_b(1, 0, 0, 8'h11, 16'h0000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt_a", 32'(gnt_a[k]), 32'd0);
      chk("rst_gnt_b", 32'(gnt_b[k]), 32'd0);
      chk("rst_mem_en", 32'(mem_en[k]), 32'd0);
      chk("rst_rvalid", 32'({rvalid_b[k], rvalid_a[k]}), 32'd0);
      chk("rst_owner", 32'(dbg_own[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(0, 0, 0, 8'h00, 16'h0000);
    drive_b(0, 0, 0, 8'h00, 16'h0000);

    // Single-port read of 8'h10.
    @(posedge clk); #1; drive_a(1, 0, 0, 8'h10, 16'h0000);
    @(negedge clk);
    chk("t1_gnt_a", 32'(gnt_a[0]), 32'd1);
    chk("t1_mem_en", 32'(mem_en[0]), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr[0]), 32'h10);
    @(posedge clk); #1; drive_a(0, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("t1_rvalid_a", 32'(rvalid_a[0]), 32'd1);
    chk("t1_rdata_a", 32'(rdata_a[0]), 32'h1234);
    chk("t1_rvalid_b", 32'(rvalid_b[0]), 32'd0);

    // Continuous contention: round-robin and both fixed-priority periods.
    do_reset();
    drive_a(1, 0, 0, 8'h10, 16'h0000);
    drive_b(1, 0, 0, 8'h11, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t2_win_m%0d_c%0d", k, i), 32'({gnt_b[k], gnt_a[k]}), 32'(seq[k][i]));
        if (i > 0) begin
          chk($sformatf("t2_rva_m%0d_c%0d", k, i), 32'(rvalid_a[k]), 32'(seq[k][i-1] == 1));
          chk($sformatf("t2_rvb_m%0d_c%0d", k, i), 32'(rvalid_b[k]), 32'(seq[k][i-1] == 2));
        end
      end
      if (rvalid_a[0]) chk("t2_rdata_a", 32'(rdata_a[0]), 32'h1234);
      if (rvalid_b[0]) chk("t2_rdata_b", 32'(rdata_b[0]), 32'hA511);
    end
    @(posedge clk); #1;
    drive_a(0, 0, 0, 8'h00, 16'h0000);
    drive_b(0, 0, 0, 8'h00, 16'h0000);

    // Locked read-modify-write by A while B waits.
    do_reset();
    drive_a(1, 0, 1, 8'h20, 16'h0000);
    drive_b(1, 0, 0, 8'h20, 16'h0000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("t4_first_a", 32'({gnt_b[k], gnt_a[k]}), 32'd1);
    @(posedge clk); #1; drive_a(1, 1, 0, 8'h20, 16'h0008);
    @(negedge clk);
    chk("t4_owner_a", 32'(dbg_own[0]), 32'd1);
    for (int k = 0; k < 3; k++) chk("t4_b_denied", 32'({gnt_b[k], gnt_a[k]}), 32'd1);
    chk("t4_write_we", 32'(mem_we[0]), 32'd1);
    chk("t4_write_data", 32'(mem_wdata[0]), 32'h0008);
    @(posedge clk); #1; drive_a(0, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("t4_b_granted", 32'(gnt_b[k]), 32'd1);
    chk("t4_owner_none", 32'(dbg_own[0]), 32'd0);
    @(posedge clk); #1; drive_b(0, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("t4_rvalid_b", 32'(rvalid_b[0]), 32'd1);
    chk("t4_rdata_b", 32'(rdata_b[0]), 32'h0008);

    // B write then read-back at the top address.
    @(posedge clk); #1; drive_b(1, 1, 0, 8'hFF, 16'hBEEF);
    @(negedge clk);
    chk("t5_gnt_b_wr", 32'(gnt_b[0]), 32'd1);
    chk("t5_mem_we", 32'(mem_we[0]), 32'd1);
    @(posedge clk); #1; drive_b(1, 0, 0, 8'hFF, 16'h0000);
    @(negedge clk);
    chk("t5_no_rvalid_wr", 32'(rvalid_b[0]), 32'd0);
    chk("t5_gnt_b_rd", 32'(gnt_b[0]), 32'd1);
    @(posedge clk); #1; drive_b(0, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("t5_rvalid_b", 32'(rvalid_b[0]), 32'd1);
    chk("t5_rdata_b", 32'(rdata_b[0]), 32'hBEEF);

    // Asynchronous reset while A holds the lock and a read is returning.
    @(posedge clk); #1; drive_a(1, 0, 1, 8'h30, 16'h0000);
    @(negedge clk);
    chk("t6_gnt_a", 32'(gnt_a[0]), 32'd1);
    @(posedge clk); #1;
    drive_a(0, 0, 1, 8'h30, 16'h0000);
    drive_b(1, 0, 0, 8'h40, 16'h0000);
    #1;
    chk("t6_owner_a", 32'(dbg_own[0]), 32'd1);
    chk("t6_rvalid_a", 32'(rvalid_a[0]), 32'd1);
    for (int k = 0; k < 3; k++) chk("t6_b_locked_out", 32'(gnt_b[k]), 32'd0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_rst_rvalid_a", 32'(rvalid_a[k]), 32'd0);
      chk("t6_rst_owner", 32'(dbg_own[k]), 32'd0);
      chk("t6_rst_strobe", 32'({mem_we[k], mem_en[k], gnt_b[k], gnt_a[k]}), 32'd0);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("t6_b_first", 32'(gnt_b[k]), 32'd1);
    chk("t6_b_addr", 32'(mem_addr[0]), 32'h40);
    @(posedge clk); #1;
    drive_a(0, 0, 0, 8'h00, 16'h0000);
    drive_b(0, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("t6_rvalid_b", 32'(rvalid_b[0]), 32'd1);
    chk("t6_rdata_b", 32'(rdata_b[0]), 32'hA540);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
